// File: rtl/mat_vec_mul_pkg.sv
// Fixed-point helpers shared by the streaming matrix-vector multiplier.
// Wide intermediates are carried in 64 bits, which bounds DATAWIDTH to 30.
package mat_vec_mul_pkg;

  function automatic int accWidth(input int dataWidth, input int n);
    return 2 * dataWidth + $clog2(n);
  endfunction

  function automatic logic signed [63:0] roundConst(input int fracBits);
    return 64'sd1 <<< (fracBits - 1);
  endfunction

  function automatic logic signed [63:0] maxSigned(input int dataWidth);
    return (64'sd1 <<< (dataWidth - 1)) - 64'sd1;
  endfunction

  function automatic logic fitsSigned(input logic signed [63:0] v, input int dataWidth);
    return (v <= maxSigned(dataWidth)) && (v >= -maxSigned(dataWidth) - 64'sd1);
  endfunction

  // In wrap mode the value passes through untouched; the caller keeps the low bits.
  function automatic logic signed [63:0] satNarrow(input logic signed [63:0] v,
                                                    input int dataWidth,
                                                    input bit saturate);
    if (!saturate || fitsSigned(v, dataWidth)) return v;
    return (v < 0) ? (-maxSigned(dataWidth) - 64'sd1) : maxSigned(dataWidth);
  endfunction

endpackage

// File: rtl/mat_vec_mul_stage.sv
// One MAC stage: adds column K of A times x[K] into every lane's partial sum
// and carries A, x and its valid bit forward to the next stage.
module mat_vec_mul_stage
  import mat_vec_mul_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int N         = 4,
  parameter int K         = 0,
  parameter int ACCW      = accWidth(DATAWIDTH, N)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en_i,
  input  logic                                 valid_i,
  input  logic [N-1:0][N-1:0][DATAWIDTH-1:0]   a_i,
  input  logic [N-1:0][DATAWIDTH-1:0]          x_i,
  input  logic [N-1:0][ACCW-1:0]               acc_i,
  output logic                                 valid_o,
  output logic [N-1:0][N-1:0][DATAWIDTH-1:0]   a_o,
  output logic [N-1:0][DATAWIDTH-1:0]          x_o,
  output logic [N-1:0][ACCW-1:0]               acc_o
);

  localparam int PRODW = 2 * DATAWIDTH;

  logic                               valid_q;
  logic [N-1:0][N-1:0][DATAWIDTH-1:0] a_q;
  logic [N-1:0][DATAWIDTH-1:0]        x_q;
  logic [N-1:0][ACCW-1:0]             acc_q;
  logic [N-1:0][ACCW-1:0]             acc_d;
  logic signed [PRODW-1:0]            prod;

  always_comb begin
    acc_d = acc_i;
    prod  = '0;
    for (int r = 0; r < N; r++) begin
      prod     = $signed(a_i[r][K]) * $signed(x_i[K]);
      acc_d[r] = acc_i[r] + {{(ACCW - PRODW){prod[PRODW-1]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
    end
  end

  // Data registers are deliberately unreset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (en_i) begin
      a_q   <= a_i;
      x_q   <= x_i;
      acc_q <= acc_d;
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign x_o     = x_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/mat_vec_mul_stream.sv
// Streaming y = A*x in signed fixed point: N MAC stages followed by a
// round/saturate output register, all advancing together under one enable.
module mat_vec_mul_stream
  import mat_vec_mul_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int FRACBITS  = 8,
  parameter int N         = 4,
  parameter int SATURATE  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0][N-1:0][DATAWIDTH-1:0]   A,
  input  logic [N-1:0][DATAWIDTH-1:0]          x,
  input  logic                                 i_dv,
  output logic                                 o_ready,
  output logic [N-1:0][DATAWIDTH-1:0]          y,
  output logic [N-1:0]                         o_sat,
  output logic                                 o_dv,
  input  logic                                 i_ready
);

  localparam int ACCW = accWidth(DATAWIDTH, N);

  logic                          en;
  logic                          dv_q;
  logic [N-1:0][DATAWIDTH-1:0]   y_q;
  logic [N-1:0][DATAWIDTH-1:0]   y_d;
  logic [N-1:0]                  sat_q;
  logic [N-1:0]                  sat_d;
  logic signed [63:0]            wide;
  logic signed [63:0]            rounded;

  wire  [N:0]                              stageValid;
  wire  [N:0][N-1:0][N-1:0][DATAWIDTH-1:0] stageA;
  wire  [N:0][N-1:0][DATAWIDTH-1:0]        stageX;
  wire  [N:0][N-1:0][ACCW-1:0]             stageAcc;
  logic                                    unusedPassThrough;

  // A full output register that downstream refuses freezes the whole pipe.
  assign en      = !dv_q || i_ready;
  assign o_ready = en;

  assign stageValid[0] = i_dv;
  assign stageA[0]     = A;
  assign stageX[0]     = x;
  assign stageAcc[0]   = '0;

  for (genvar k = 0; k < N; k++) begin : g_stage
    mat_vec_mul_stage #(
      .DATAWIDTH(DATAWIDTH),
      .N        (N),
      .K        (k),
      .ACCW     (ACCW)
    ) uStage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .valid_i(stageValid[k]),
      .a_i    (stageA[k]),
      .x_i    (stageX[k]),
      .acc_i  (stageAcc[k]),
      .valid_o(stageValid[k+1]),
      .a_o    (stageA[k+1]),
      .x_o    (stageX[k+1]),
      .acc_o  (stageAcc[k+1])
    );
  end

  // The last stage's pass-through of A and x has no consumer.
  assign unusedPassThrough = ^{stageA[N], stageX[N]};

  always_comb begin
    y_d     = '0;
    sat_d   = '0;
    wide    = '0;
    rounded = '0;
    for (int r = 0; r < N; r++) begin
      wide     = {{(64 - ACCW){stageAcc[N][r][ACCW-1]}}, stageAcc[N][r]};
      rounded  = (wide + roundConst(FRACBITS)) >>> FRACBITS;
      y_d[r]   = DATAWIDTH'(satNarrow(rounded, DATAWIDTH, SATURATE != 0));
      sat_d[r] = !fitsSigned(rounded, DATAWIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q  <= 1'b0;
      y_q   <= '0;
      sat_q <= '0;
    end else if (en) begin
      dv_q <= stageValid[N];
      if (stageValid[N]) begin
        y_q   <= y_d;
        sat_q <= sat_d;
      end
    end
  end

  assign o_dv  = dv_q;
  assign y     = y_q;
  assign o_sat = sat_q;

endmodule

// File: tb/tb_mat_vec_mul_stream.sv
// Directed bench for mat_vec_mul_stream (16-bit Q8.8, N=4): a saturating and a
// wrapping instance share stimulus from a table of hand-computed vectors.
module tb_mat_vec_mul_stream;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NN = 4;

  typedef struct packed {
    logic [NN-1:0][NN-1:0][DW-1:0] a;
    logic [NN-1:0][DW-1:0]         x;
    logic [NN-1:0][DW-1:0]         expY;
    logic [NN-1:0]                 expSat;
    logic [NN-1:0][DW-1:0]         expYWrap;
    logic [NN-1:0]                 expSatWrap;
  } vec_t;

  vec_t vec [8];

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NN-1:0][NN-1:0][DW-1:0] a;
  logic [NN-1:0][DW-1:0]         xv;
  logic                          iDv;
  logic                          iReady;
  logic                          oReady, oReadyW;
  logic [NN-1:0][DW-1:0]         y, yW;
  logic [NN-1:0]                 oSat, oSatW;
  logic                          oDv, oDvW;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mat_vec_mul_stream #(.DATAWIDTH(DW), .FRACBITS(FB), .N(NN), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .A(a), .x(xv), .i_dv(iDv), .o_ready(oReady),
    .y(y), .o_sat(oSat), .o_dv(oDv), .i_ready(iReady)
  );

  mat_vec_mul_stream #(.DATAWIDTH(DW), .FRACBITS(FB), .N(NN), .SATURATE(0)) dutWrap (
    .clk(clk), .rst(rst), .A(a), .x(xv), .i_dv(iDv), .o_ready(oReadyW),
    .y(yW), .o_sat(oSatW), .o_dv(oDvW), .i_ready(iReady)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic dv, input int idx);
    iDv = dv;
    a   = vec[idx].a;
    xv  = vec[idx].x;
  endtask

  task automatic fillTable();
    for (int i = 0; i < 8; i++) vec[i] = '0;
    // 0: identity
    for (int i = 0; i < NN; i++) vec[0].a[i][i] = 16'h0100;
    vec[0].x[0] = 16'h0100; vec[0].x[1] = 16'hFF00; vec[0].x[2] = 16'h0280; vec[0].x[3] = 16'h0000;
    vec[0].expY = vec[0].x;  vec[0].expYWrap = vec[0].x;
    // 1, 2: half-LSB rounds up, negative half-LSB rounds to zero
    vec[1].a[0][0] = 16'h0001; vec[1].x[0] = 16'h0080; vec[1].expY[0] = 16'h0001; vec[1].expYWrap[0] = 16'h0001;
    vec[2].a[0][0] = 16'h0001; vec[2].x[0] = 16'hFF80;
    // 3, 4: full-scale overflow in both directions
    for (int r = 0; r < NN; r++) begin
      vec[3].x[r] = 16'h7FFF; vec[4].x[r] = 16'h7FFF;
      vec[3].expY[r] = 16'h7FFF; vec[3].expYWrap[r] = 16'hFC00;
      vec[4].expY[r] = 16'h8000; vec[4].expYWrap[r] = 16'h0200;
      for (int c = 0; c < NN; c++) begin
        vec[3].a[r][c] = 16'h7FFF;
        vec[4].a[r][c] = 16'h8000;
      end
    end
    vec[3].expSat = 4'b1111; vec[3].expSatWrap = 4'b1111;
    vec[4].expSat = 4'b1111; vec[4].expSatWrap = 4'b1111;
    // 5: mixed general case, y = {3, -1, 1, 5}
    vec[5].a[0][0] = 16'h0200; vec[5].a[0][1] = 16'h0080;
    vec[5].a[1][0] = 16'hFF00; vec[5].a[1][1] = 16'h0100; vec[5].a[1][2] = 16'h0100;
    vec[5].a[2][3] = 16'h0040;
    for (int c = 0; c < NN; c++) vec[5].a[3][c] = 16'h0100;
    vec[5].x[0] = 16'h0100; vec[5].x[1] = 16'h0200; vec[5].x[2] = 16'hFE00; vec[5].x[3] = 16'h0400;
    vec[5].expY[0] = 16'h0300; vec[5].expY[1] = 16'hFF00; vec[5].expY[2] = 16'h0100; vec[5].expY[3] = 16'h0500;
    vec[5].expYWrap = vec[5].expY;
    // 6: per-lane rounding of odd fractions, including a negative result
    vec[6].a[1][1] = 16'h0001; vec[6].a[2][2] = 16'h0003; vec[6].a[3][3] = 16'hFFFF;
    vec[6].x[1] = 16'h0180; vec[6].x[2] = 16'h0055; vec[6].x[3] = 16'h0081;
    vec[6].expY[1] = 16'h0002; vec[6].expY[2] = 16'h0001; vec[6].expY[3] = 16'hFFFF;
    vec[6].expYWrap = vec[6].expY;
    // 7: exactly at both limits (lanes 0,1) and one LSB beyond (lanes 2,3)
    vec[7].a[0][0] = 16'h7FFF; vec[7].a[1][0] = 16'h8000;
    vec[7].a[2][0] = 16'h7FFF; vec[7].a[2][1] = 16'h0001;
    vec[7].a[3][0] = 16'h8000; vec[7].a[3][1] = 16'hFFFF;
    vec[7].x[0] = 16'h0100; vec[7].x[1] = 16'h0100;
    vec[7].expY[0] = 16'h7FFF; vec[7].expY[1] = 16'h8000; vec[7].expY[2] = 16'h7FFF; vec[7].expY[3] = 16'h8000;
    vec[7].expYWrap[0] = 16'h7FFF; vec[7].expYWrap[1] = 16'h8000;
    vec[7].expYWrap[2] = 16'h8000; vec[7].expYWrap[3] = 16'h7FFF;
    vec[7].expSat = 4'b1100; vec[7].expSatWrap = 4'b1100;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int latency;
    int sendIdx;
    int outCount;
    int sb[$];

    fillTable();
    rst = 1'b1; iDv = 1'b0; iReady = 1'b1; a = '0; xv = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset o_dv", oDv, 0);
    checkOutput("reset y", y, 0);
    checkOutput("reset o_sat", oSat, 0);
    checkOutput("reset o_ready", oReady, 1);
    checkOutput("reset wrap o_ready", oReadyW, 1);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      applyStimulus(1'b1, v);
      iReady = 1'b1;
      @(negedge clk);
      iDv = 1'b0;
      latency = 1;
      while (!oDv && latency < 20) begin
        @(negedge clk);
        latency++;
      end
      checkOutput($sformatf("v%0d latency", v), latency, 5);
      checkOutput($sformatf("v%0d o_dv", v), oDv, 1);
      checkOutput($sformatf("v%0d y", v), y, vec[v].expY);
      checkOutput($sformatf("v%0d o_sat", v), oSat, vec[v].expSat);
      checkOutput($sformatf("v%0d wrap o_dv", v), oDvW, 1);
      checkOutput($sformatf("v%0d wrap y", v), yW, vec[v].expYWrap);
      checkOutput($sformatf("v%0d wrap o_sat", v), oSatW, vec[v].expSatWrap);
    end

    // Back-to-back stream of vectors 0..5 with downstream stalled in cycles 7..9.
    sendIdx = 0;
    outCount = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      iReady = !(c >= 7 && c <= 9);
      if (c >= 2 && sendIdx < 6) applyStimulus(1'b1, sendIdx);
      else iDv = 1'b0;
      #1;
      checkOutput($sformatf("bp c%0d o_ready", c), oReady, (c >= 7 && c <= 9) ? 1'b0 : 1'b1);
      if (c >= 7 && c <= 9) checkOutput($sformatf("bp c%0d stall o_dv", c), oDv, 1);
      if (oDv) begin
        if (sb.size() == 0) begin
          checkOutput($sformatf("bp c%0d unexpected o_dv", c), oDv, 0);
        end else begin
          checkOutput($sformatf("bp c%0d y", c), y, vec[sb[0]].expY);
          checkOutput($sformatf("bp c%0d o_sat", c), oSat, vec[sb[0]].expSat);
          if (iReady) begin
            void'(sb.pop_front());
            outCount++;
          end
        end
      end
      if (iDv && oReady) begin
        sb.push_back(sendIdx);
        sendIdx++;
      end
    end
    checkOutput("bp accepted count", sendIdx, 6);
    checkOutput("bp emitted count", outCount, 6);

    // Reset with vectors 3,4,5 in flight, then one fresh vector.
    iReady = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rst = (c == 3);
      if (c <= 2) applyStimulus(1'b1, 3 + c);
      else if (c == 4) applyStimulus(1'b1, 6);
      else iDv = 1'b0;
      #1;
      if (c == 4) begin
        checkOutput("rst o_dv", oDv, 0);
        checkOutput("rst y", y, 0);
        checkOutput("rst o_sat", oSat, 0);
        checkOutput("rst wrap y", yW, 0);
        checkOutput("rst wrap o_sat", oSatW, 0);
        checkOutput("rst o_ready", oReady, 1);
      end else if (c == 9) begin
        checkOutput("rst new o_dv", oDv, 1);
        checkOutput("rst new y", y, vec[6].expY);
        checkOutput("rst new o_sat", oSat, vec[6].expSat);
      end else if (c >= 5) begin
        checkOutput($sformatf("rst c%0d o_dv", c), oDv, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
